// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer.
package rst_seq_pkg;

  // Sequencer states; encodings are visible on the debug port.
  typedef enum logic [2:0] {
    S_WLOCK = 3'd0,
    S_GAP1  = 3'd1,
    S_GAP2  = 3'd2,
    S_RUN   = 3'd3,
    S_HOLD  = 3'd4
  } rst_state_e;

  localparam int unsigned LockWaitDef = 1024;
  localparam int unsigned StageGapDef = 16;
  localparam int unsigned SwHoldDef   = 64;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync2.sv
// Generic two-flop bit synchronizer, asynchronously cleared to 0.
module rst_seq_ctrl_sync2 (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: qualifies PLL lock, then releases mem -> ppu -> cpu resets in order.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned LOCK_WAIT = LockWaitDef,
  parameter int unsigned STAGE_GAP = StageGapDef,
  parameter int unsigned SW_HOLD   = SwHoldDef
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_pll_locked,
  input  logic       i_sw_rst,
  output logic       o_srstn_mem,
  output logic       o_srstn_ppu,
  output logic       o_srstn_cpu,
  output logic       o_ready,
  output logic [2:0] o_state
);

  localparam int unsigned CntMax = max3(LOCK_WAIT, STAGE_GAP, SW_HOLD);
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] LockLast = CntW'(LOCK_WAIT - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(STAGE_GAP - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(SW_HOLD - 1);

  logic            lock_s;
  rst_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_q, mem_d;
  logic            ppu_q, ppu_d;
  logic            cpu_q, cpu_d;
  logic            ready_q, ready_d;

  rst_seq_ctrl_sync2 u_lock_sync (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_d    (i_pll_locked),
    .o_q    (lock_s)
  );

  // State, counter and registered reset outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_WLOCK;
      cnt_q   <= '0;
      mem_q   <= 1'b0;
      ppu_q   <= 1'b0;
      cpu_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      ppu_q   <= ppu_d;
      cpu_q   <= cpu_d;
      ready_q <= ready_d;
    end
  end

  // Next-state, counter and output decisions; aborts take priority over sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    ppu_d   = ppu_q;
    cpu_d   = cpu_q;
    ready_d = ready_q;

    unique case (state_q)
      S_WLOCK: begin
        mem_d   = 1'b0;
        ppu_d   = 1'b0;
        cpu_d   = 1'b0;
        ready_d = 1'b0;
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == LockLast) begin
          state_d = S_GAP1;
          mem_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      S_GAP1, S_GAP2, S_RUN, S_HOLD: begin
        if (!lock_s) begin
          // Lock loss wins over a coincident software request.
          state_d = S_WLOCK;
          cnt_d   = '0;
          mem_d   = 1'b0;
          ppu_d   = 1'b0;
          cpu_d   = 1'b0;
          ready_d = 1'b0;
        end else if (i_sw_rst && (state_q != S_HOLD)) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          mem_d   = 1'b0;
          ppu_d   = 1'b0;
          cpu_d   = 1'b0;
          ready_d = 1'b0;
        end else if (state_q == S_GAP1) begin
          if (cnt_q == GapLast) begin
            state_d = S_GAP2;
            ppu_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (state_q == S_GAP2) begin
          if (cnt_q == GapLast) begin
            state_d = S_RUN;
            cpu_d   = 1'b1;
            ready_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (state_q == S_HOLD) begin
          // A held request keeps restarting the hold window.
          if (i_sw_rst) begin
            cnt_d = '0;
          end else if (cnt_q == HoldLast) begin
            state_d = S_WLOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      default: begin
        state_d = S_WLOCK;
        cnt_d   = '0;
        mem_d   = 1'b0;
        ppu_d   = 1'b0;
        cpu_d   = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign o_srstn_mem = mem_q;
  assign o_srstn_ppu = ppu_q;
  assign o_srstn_cpu = cpu_q;
  assign o_ready     = ready_q;
  assign o_state     = state_q;

endmodule
